// File: rtl/pe_in_pkt_if.sv
`default_nettype none
// ============================================================================
// Module   : pe_in_pkt_if
// Purpose  : PE input packet bundle between the packet sequencer (master)
//            and the buffered multiplier array (slave).
//            PE_state codes: 0 = INVALID, 1 = VALID, 2 = CNN_FIN.
// Revision : 1.0 - initial release
// ============================================================================
interface pe_in_pkt_if #(
  parameter int DATA_WID = 8,
  parameter int ADDR_B   = 4,
  parameter int MUL_NUM  = 4
);
  logic [MUL_NUM-1:0][DATA_WID-1:0] A;
  logic [MUL_NUM-1:0]               wrb;
  logic [DATA_WID-1:0]              wrb_data;
  logic [ADDR_B-1:0]                wrb_addr;
  logic [ADDR_B-1:0]                rdb_addr;
  logic [1:0]                       PE_state;

  modport master (output A, wrb, wrb_data, wrb_addr, rdb_addr, PE_state);
  modport slave  (input  A, wrb, wrb_data, wrb_addr, rdb_addr, PE_state);
endinterface
`default_nettype wire

// File: rtl/pe_in_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module   : pe_in_pkt_gen
// Purpose  : Loads one kernel of CAP_B weights into the PE B-buffers, then
//            streams CAP_B activation vectors with read addresses, tagging
//            the final beat CNN_FIN. All packet fields are registered.
// Revision : 1.0 - initial release
// ============================================================================
module pe_in_pkt_gen #(
  parameter int DATA_WID = 8,
  parameter int ADDR_B   = 4,
  parameter int CAP_B    = 9,
  parameter int MUL_NUM  = 4
) (
  input  wire logic                             clk,
  input  wire logic                             reset,
  input  wire logic                             start_i,
  input  wire logic [MUL_NUM-1:0]               start_mask_i,
  input  wire logic                             wt_valid_i,
  input  wire logic [DATA_WID-1:0]              wt_data_i,
  output logic                                  wt_ready_o,
  input  wire logic                             act_valid_i,
  input  wire logic [MUL_NUM-1:0][DATA_WID-1:0] act_data_i,
  output logic                                  act_ready_o,
  pe_in_pkt_if.master                           pe_in_pk,
  output logic                                  busy_o,
  output logic                                  done_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [1:0] PE_INVALID = 2'd0;
  localparam logic [1:0] PE_VALID   = 2'd1;
  localparam logic [1:0] PE_CNN_FIN = 2'd2;

  localparam logic [ADDR_B-1:0] CNT_LAST = ADDR_B'(CAP_B - 1);
  localparam logic [ADDR_B-1:0] CNT_ONE  = ADDR_B'(1);

  logic [1:0]                       state_q,    state_d;
  logic [ADDR_B-1:0]                cnt_q,      cnt_d;
  logic [MUL_NUM-1:0]               mask_q,     mask_d;
  logic                             done_q,     done_d;
  logic [MUL_NUM-1:0][DATA_WID-1:0] a_q,        a_d;
  logic [MUL_NUM-1:0]               wrb_q,      wrb_d;
  logic [DATA_WID-1:0]              wrb_data_q, wrb_data_d;
  logic [ADDR_B-1:0]                wrb_addr_q, wrb_addr_d;
  logic [ADDR_B-1:0]                rdb_addr_q, rdb_addr_d;
  logic [1:0]                       pe_state_q, pe_state_d;

  // Next-state and packet computation; wrb and PE_state default to idle
  // values every cycle so only handshake cycles produce activity.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    done_d     = 1'b0;
    a_d        = a_q;
    wrb_d      = '0;
    wrb_data_d = wrb_data_q;
    wrb_addr_d = wrb_addr_q;
    rdb_addr_d = rdb_addr_q;
    pe_state_d = PE_INVALID;
    case (state_q)
      S_IDLE: begin
        // done_q marks the cycle right after DONE; start is ignored there.
        if (start_i && !done_q) begin
          mask_d  = start_mask_i;
          state_d = (|start_mask_i) ? S_LOAD : S_STREAM;
        end
      end
      S_LOAD: begin
        if (wt_valid_i) begin
          wrb_d      = mask_q;
          wrb_data_d = wt_data_i;
          wrb_addr_d = cnt_q;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_STREAM;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_STREAM: begin
        if (act_valid_i) begin
          a_d        = act_data_i;
          rdb_addr_d = cnt_q;
          if (cnt_q == CNT_LAST) begin
            pe_state_d = PE_CNN_FIN;
            cnt_d      = '0;
            state_d    = S_DONE;
          end else begin
            pe_state_d = PE_VALID;
            cnt_d      = cnt_q + CNT_ONE;
          end
        end
      end
      S_DONE: begin
        // CNN_FIN is on the packet during this state; done follows it.
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and packet registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mask_q     <= '0;
      done_q     <= 1'b0;
      a_q        <= '0;
      wrb_q      <= '0;
      wrb_data_q <= '0;
      wrb_addr_q <= '0;
      rdb_addr_q <= '0;
      pe_state_q <= PE_INVALID;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      done_q     <= done_d;
      a_q        <= a_d;
      wrb_q      <= wrb_d;
      wrb_data_q <= wrb_data_d;
      wrb_addr_q <= wrb_addr_d;
      rdb_addr_q <= rdb_addr_d;
      pe_state_q <= pe_state_d;
    end
  end

  // Handshake readies decode from state only, no path from the valids.
  assign wt_ready_o  = (state_q == S_LOAD);
  assign act_ready_o = (state_q == S_STREAM);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;

  assign pe_in_pk.A        = a_q;
  assign pe_in_pk.wrb      = wrb_q;
  assign pe_in_pk.wrb_data = wrb_data_q;
  assign pe_in_pk.wrb_addr = wrb_addr_q;
  assign pe_in_pk.rdb_addr = rdb_addr_q;
  assign pe_in_pk.PE_state = pe_state_q;

endmodule
`default_nettype wire
